coef_host_loader: RTL and testbench

Host-side byte-stream front end for the coefficient RAM's read/write port. It parses write and read commands arriving as a byte stream and assembles 36-bit coefficient words into single-cycle RAM writes. For read commands it fetches words through the RAM's registered read path and serialises them back to the host. It sits between the host link (UART/SPI byte layer) and the L/R coefficient RAM read/write ports; the filter-side coefficient read ports are untouched.

---
 rtl/coef_host_loader.sv | 172 +++++++++++++++++
 tb/tb_coef_host_loader.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_host_loader.sv
// Byte-stream host front end for the L/R coefficient RAM read/write ports.
// Parses write/read frames, assembles 36-bit words for writes and serialises readback words.
module coef_host_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [13:0] addrLrw,
  output logic [35:0] datainLrw,
  output logic        weL,
  input  logic [35:0] dataoutLrw,
  output logic [13:0] addrRrw,
  output logic [35:0] datainRrw,
  output logic        weR,
  input  logic [35:0] dataoutRrw,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, A_HI, A_LO, CNT, WR_BYTE, WR_COMMIT, RD_ISSUE, RD_WAIT, RD_SEND
  } stateType;

  stateType    state, nextState;
  logic [13:0] addr;
  logic [7:0]  wordLimit;
  logic [7:0]  wordCnt;
  logic [2:0]  byteIdx;
  logic [35:0] shiftReg;
  logic [39:0] txShift;
  logic        opRead;
  logic        chRight;
  logic        errReg;
  logic        rxAccept;
  logic        lastWord;
  logic        lastByte;
  logic        cmdBad;

  assign rxAccept = rx_valid && rx_ready;
  assign lastWord = (wordCnt == wordLimit);
  assign lastByte = (byteIdx == 3'd4);
  assign cmdBad   = (rx_data[5:0] != 6'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Handshake and enable outputs are forced low while reset is high so an aborted frame never strobes.
  always_comb begin
    nextState = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    weL       = 1'b0;
    weR       = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && !cmdBad) nextState = A_HI;
      end
      A_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) nextState = A_LO;
      end
      A_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) nextState = CNT;
      end
      CNT: begin
        rx_ready = 1'b1;
        if (rx_valid) nextState = opRead ? RD_ISSUE : WR_BYTE;
      end
      WR_BYTE: begin
        rx_ready = 1'b1;
        if (rx_valid && lastByte) nextState = WR_COMMIT;
      end
      WR_COMMIT: begin
        weL       = !chRight;
        weR       = chRight;
        nextState = lastWord ? IDLE : WR_BYTE;
      end
      RD_ISSUE: nextState = RD_WAIT;
      RD_WAIT:  nextState = RD_SEND;
      RD_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && lastByte) nextState = lastWord ? IDLE : RD_ISSUE;
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      weL      = 1'b0;
      weR      = 1'b0;
    end
  end

  // Address only advances on leaving WR_COMMIT or RD_SEND, so it is stable from issue to capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr      <= '0;
      wordLimit <= '0;
      wordCnt   <= '0;
      byteIdx   <= '0;
      shiftReg  <= '0;
      txShift   <= '0;
      opRead    <= 1'b0;
      chRight   <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      errReg <= 1'b0;
      case (state)
        IDLE: begin
          if (rxAccept) begin
            if (cmdBad) errReg <= 1'b1;
            else {opRead, chRight} <= rx_data[7:6];
          end
        end
        A_HI: if (rxAccept) addr[13:8] <= rx_data[5:0];
        A_LO: if (rxAccept) addr[7:0] <= rx_data;
        CNT: begin
          if (rxAccept) begin
            wordLimit <= rx_data;
            wordCnt   <= '0;
            byteIdx   <= '0;
          end
        end
        WR_BYTE: begin
          if (rxAccept) begin
            shiftReg <= {shiftReg[27:0], rx_data};
            byteIdx  <= lastByte ? 3'd0 : byteIdx + 3'd1;
          end
        end
        WR_COMMIT: begin
          if (!lastWord) begin
            addr    <= addr + 14'd1;
            wordCnt <= wordCnt + 8'd1;
          end
        end
        RD_WAIT: txShift <= {4'b0000, chRight ? dataoutRrw : dataoutLrw};
        RD_SEND: begin
          if (tx_ready) begin
            txShift <= {txShift[31:0], 8'h00};
            if (lastByte) begin
              byteIdx <= '0;
              if (!lastWord) begin
                addr    <= addr + 14'd1;
                wordCnt <= wordCnt + 8'd1;
              end
            end else begin
              byteIdx <= byteIdx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign addrLrw   = addr;
  assign addrRrw   = addr;
  assign datainLrw = shiftReg;
  assign datainRrw = shiftReg;
  assign tx_data   = txShift[39:32];
  assign err       = errReg;
  assign busy      = (state != IDLE) && !reset;

endmodule

// File: tb/tb_coef_host_loader.sv
// Self-checking bench for coef_host_loader: behavioural RAM, reference memory image and
// scoreboard queues of expected RAM writes and readback bytes.
module tb_coef_host_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [13:0] addrLrw, addrRrw;
  logic [35:0] datainLrw, datainRrw;
  logic [35:0] dataoutLrw, dataoutRrw;
  logic        weL, weR, busy, err;

  int errors = 0;
  int checks = 0;
  bit gapMode = 1'b0;

  logic [35:0] memL [0:16383];
  logic [35:0] memR [0:16383];
  logic [35:0] refMem [0:1][0:16383];
  logic [50:0] weQ[$];
  logic [7:0]  txQ[$];

  logic        pokeEn = 1'b0;
  logic        pokeCh = 1'b0;
  logic [13:0] pokeAddr = '0;
  logic [35:0] pokeData = '0;

  always #5 clock = ~clock;

  coef_host_loader dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addrLrw(addrLrw), .datainLrw(datainLrw), .weL(weL), .dataoutLrw(dataoutLrw),
    .addrRrw(addrRrw), .datainRrw(datainRrw), .weR(weR), .dataoutRrw(dataoutRrw),
    .busy(busy), .err(err)
  );

  // Coefficient RAM with registered read path
  always @(posedge clock) begin
    if (pokeEn && !pokeCh) memL[pokeAddr] <= pokeData;
    if (pokeEn && pokeCh)  memR[pokeAddr] <= pokeData;
    if (weL) memL[addrLrw] <= datainLrw;
    if (weR) memR[addrRrw] <= datainRrw;
    dataoutLrw <= memL[addrLrw];
    dataoutRrw <= memR[addrRrw];
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (weL) weQ.push_back({1'b0, addrLrw, datainLrw});
      if (weR) weQ.push_back({1'b1, addrRrw, datainRrw});
      if (tx_valid && tx_ready) txQ.push_back(tx_data);
    end
  end

  function automatic logic [7:0] wordByte(input logic [35:0] w, input int k);
    logic [39:0] v;
    v = {4'b0000, w};
    return v[39-8*k -: 8];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (gapMode) repeat ($urandom_range(0, 2)) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    while (!rx_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!rx_ready) begin
      errors++;
      checks++;
      $display("[TB] FAIL rx_accept_timeout: byte %02h rx_ready=%b required 1", b, rx_ready);
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendHeader(input bit op, input bit ch, input logic [13:0] a, input logic [7:0] n);
    sendByte({op, ch, 6'b000000});
    sendByte({2'b00, a[13:8]});
    sendByte(a[7:0]);
    sendByte(n);
  endtask

  // Upper nibble of the first byte is junk that the loader must ignore
  task automatic sendWord(input logic [35:0] w);
    logic [3:0] junk;
    junk = 4'($urandom_range(0, 15));
    sendByte({junk, w[35:32]});
    for (int k = 1; k < 5; k++) sendByte(wordByte(w, k));
  endtask

  task automatic waitIdle(input int budget, input bit randReady, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      if (randReady) tx_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    tx_ready = 1'b1;
    if (busy) begin
      errors++;
      checks++;
      $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({rx_ready, tx_valid, busy, err, weL, weR} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000", {rx_ready, tx_valid, busy, err, weL, weR});
    end
    checks++;
    if ({addrLrw, addrRrw} !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h/%h required 0", addrLrw, addrRrw);
    end
    checks++;
    if ({datainLrw, datainRrw, tx_data} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h/%h/%h required 0", datainLrw, datainRrw, tx_data);
    end
    @(posedge clock); #1;
    reset = 1'b0; tx_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({rx_ready, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_release: rx_ready,busy got %b required 10", {rx_ready, busy});
    end
    tick();
  endtask

  task automatic test_write_single();
    weQ.delete();
    sendByte(8'h00);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_cmd: got %b required 1", busy);
    end
    tick();
    sendByte(8'h00); sendByte(8'h05); sendByte(8'h00);
    sendByte(8'h09); sendByte(8'hAB); sendByte(8'hCD); sendByte(8'hEF); sendByte(8'h01);
    @(negedge clock);
    checks++;
    if ({weL, weR, addrLrw, datainLrw} !== {2'b10, 14'h0005, 36'h9ABCDEF01}) begin
      errors++;
      $display("[TB] FAIL write_single_commit: we=%b%b addr=%h data=%h required 10/0005/9abcdef01",
               weL, weR, addrLrw, datainLrw);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({weL, weR, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL write_single_after: we,busy got %b required 000", {weL, weR, busy});
    end
    tick();
    checks++;
    if (weQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL write_single_count: got %0d writes required 1", weQ.size());
    end
    refMem[0][14'h0005] = 36'h9ABCDEF01;
  endtask

  task automatic test_write_wrap();
    int cyc;
    weQ.delete();
    sendHeader(1'b0, 1'b1, 14'h3FFF, 8'h01);
    sendWord(36'h000000011);
    sendWord(36'h000000022);
    waitIdle(20, 1'b0, cyc);
    checks++;
    if (weQ.size() != 2 || weQ[0] !== {1'b1, 14'h3FFF, 36'h11} || weQ[1] !== {1'b1, 14'h0000, 36'h22}) begin
      errors++;
      $display("[TB] FAIL write_wrap: got %0d writes first=%h required 2 writes R@3fff=11, R@0000=22",
               weQ.size(), (weQ.size() > 0) ? weQ[0] : 51'h0);
    end
    refMem[1][14'h3FFF] = 36'h11;
    refMem[1][14'h0000] = 36'h22;
  endtask

  task automatic test_read_backpressure();
    int firstValid;
    int unstable;
    int rxHigh;
    logic prevStall;
    logic [7:0] prevData;
    logic [7:0] got[$];
    firstValid = -1; unstable = 0; rxHigh = 0; prevStall = 1'b0; prevData = 8'h00;
    pokeEn = 1'b1; pokeCh = 1'b0; pokeAddr = 14'h0010; pokeData = 36'hF12345678;
    tick();
    pokeEn = 1'b0;
    refMem[0][14'h0010] = 36'hF12345678;
    sendHeader(1'b1, 1'b0, 14'h0010, 8'h00);
    for (int cyc = 0; cyc < 80; cyc++) begin
      tx_ready = (cyc % 3 == 2);
      rx_valid = (cyc < 10);
      rx_data  = 8'hAA;
      @(negedge clock);
      if (tx_valid && firstValid < 0) firstValid = cyc;
      if (rx_ready) rxHigh++;
      if (prevStall && (!tx_valid || tx_data !== prevData)) unstable++;
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      tick();
      if (!busy) break;
    end
    rx_valid = 1'b0; tx_ready = 1'b1;
    checks++;
    if (firstValid != 2) begin
      errors++;
      $display("[TB] FAIL read_latency: first tx_valid at cycle %0d required 2", firstValid);
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("[TB] FAIL read_bp_count: got %0d bytes required 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== wordByte(refMem[0][14'h0010], k)) begin
          errors++;
          $display("[TB] FAIL read_bp_byte%0d: got %02h required %02h", k, got[k], wordByte(refMem[0][14'h0010], k));
        end
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL tx_stable: %0d unstable stalled cycles, required 0", unstable);
    end
    checks++;
    if (rxHigh != 0) begin
      errors++;
      $display("[TB] FAIL rx_ready_during_read: high %0d cycles, required 0", rxHigh);
    end
  endtask

  task automatic test_bad_cmd();
    logic [13:0] a;
    logic [35:0] w;
    int cyc;
    sendByte(8'h21);
    @(negedge clock);
    checks++;
    if ({err, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bad_cmd_err: err,busy got %b required 10", {err, busy});
    end
    tick();
    @(negedge clock);
    checks++;
    if ({err, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bad_cmd_pulse: err,busy got %b required 00", {err, busy});
    end
    tick();
    a = 14'($urandom);
    w = {4'($urandom_range(0, 15)), 32'($urandom)};
    weQ.delete();
    sendHeader(1'b0, 1'b0, a, 8'h00);
    sendWord(w);
    waitIdle(20, 1'b0, cyc);
    checks++;
    if (weQ.size() != 1 || weQ[0] !== {1'b0, a, w}) begin
      errors++;
      $display("[TB] FAIL bad_cmd_recover: got %0d writes required 1 write L@%h=%h", weQ.size(), a, w);
    end
    refMem[0][a] = w;
  endtask

  task automatic test_reset_mid_frame();
    logic [35:0] w;
    int cyc;
    int g;
    weQ.delete();
    sendHeader(1'b0, 1'b0, 14'h0200, 8'h00);
    sendByte(8'h01); sendByte(8'h23); sendByte(8'h45);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({weL, weR, rx_ready, busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_write: we,rx_ready,busy got %b required 0000", {weL, weR, rx_ready, busy});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (weQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_write_nowrite: got %0d writes required 0", weQ.size());
    end
    w = {4'($urandom_range(0, 15)), 32'($urandom)};
    sendHeader(1'b0, 1'b0, 14'h0200, 8'h00);
    sendWord(w);
    waitIdle(20, 1'b0, cyc);
    checks++;
    if (weQ.size() != 1 || weQ[0] !== {1'b0, 14'h0200, w}) begin
      errors++;
      $display("[TB] FAIL reset_fresh_write: got %0d writes required 1 write L@0200=%h", weQ.size(), w);
    end
    refMem[0][14'h0200] = w;
    tx_ready = 1'b0;
    sendHeader(1'b1, 1'b0, 14'h0200, 8'h01);
    g = 0;
    while (!tx_valid && g < 10) begin
      tick();
      g++;
    end
    checks++;
    if (!tx_valid) begin
      errors++;
      $display("[TB] FAIL read_start: tx_valid=%b after %0d cycles required 1", tx_valid, g);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_read: tx_valid got %b required 0", tx_valid);
    end
    @(posedge clock); #1;
    reset = 1'b0; tx_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_read_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic test_read_after_write();
    logic [35:0] w [4];
    int cyc;
    int bad;
    weQ.delete();
    for (int i = 0; i < 4; i++) w[i] = {4'($urandom_range(0, 15)), 32'($urandom)} ^ 36'(i);
    sendHeader(1'b0, 1'b0, 14'h0100, 8'h03);
    for (int i = 0; i < 4; i++) sendWord(w[i]);
    waitIdle(50, 1'b0, cyc);
    bad = (weQ.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && bad == 0; i++)
      if (weQ[i] !== {1'b0, 14'(14'h0100 + i), w[i]}) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL raw_writes: got %0d writes required 4 at L@0100..0103", weQ.size());
    end
    for (int i = 0; i < 4; i++) refMem[0][14'h0100 + i] = w[i];
    txQ.delete();
    tx_ready = 1'b1;
    sendHeader(1'b1, 1'b0, 14'h0100, 8'h03);
    waitIdle(100, 1'b0, cyc);
    checks++;
    if (cyc != 28) begin
      errors++;
      $display("[TB] FAIL raw_read_cycles: got %0d cycles required 28", cyc);
    end
    bad = (txQ.size() != 20) ? 1 : 0;
    for (int i = 0; i < 20 && bad == 0; i++)
      if (txQ[i] !== wordByte(refMem[0][14'h0100 + i / 5], i % 5)) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL raw_read_bytes: got %0d bytes (or wrong values) required 20 matching", txQ.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [50:0] expW[$];
    logic [7:0]  expT[$];
    logic [13:0] base, a;
    logic [35:0] w;
    logic [7:0]  n;
    bit          ch;
    int          cyc;
    int          bad;
    gapMode = 1'b1;
    for (int it = 0; it < 8; it++) begin
      ch   = 1'($urandom_range(0, 1));
      base = (it % 3 == 0) ? 14'h3FFE : 14'($urandom);
      n    = 8'($urandom_range(0, 5));
      expW.delete();
      weQ.delete();
      sendHeader(1'b0, ch, base, n);
      a = base;
      for (int i = 0; i <= int'(n); i++) begin
        w = {4'($urandom_range(0, 15)), 32'($urandom)};
        sendWord(w);
        expW.push_back({ch, a, w});
        refMem[ch][a] = w;
        a = a + 14'd1;
      end
      waitIdle(200, 1'b0, cyc);
      bad = (weQ.size() != expW.size()) ? 1 : 0;
      for (int i = 0; i < expW.size() && bad == 0; i++) if (weQ[i] !== expW[i]) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL rand_write_%0d: got %0d writes required %0d (ch=%0d base=%h)",
                 it, weQ.size(), expW.size(), ch, base);
      end
      expT.delete();
      txQ.delete();
      a = base;
      for (int i = 0; i <= int'(n); i++) begin
        for (int k = 0; k < 5; k++) expT.push_back(wordByte(refMem[ch][a], k));
        a = a + 14'd1;
      end
      sendHeader(1'b1, ch, base, n);
      waitIdle(400, 1'b1, cyc);
      bad = (txQ.size() != expT.size()) ? 1 : 0;
      for (int i = 0; i < expT.size() && bad == 0; i++) if (txQ[i] !== expT[i]) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("[TB] FAIL rand_read_%0d: got %0d bytes required %0d matching (ch=%0d base=%h)",
                 it, txQ.size(), expT.size(), ch, base);
      end
    end
    gapMode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_write_wrap();
    test_read_backpressure();
    test_bad_cmd();
    test_reset_mid_frame();
    test_read_after_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
